// File: rtl/mips_pkg.sv
// Shared constants for the multicycle MIPS control unit: state encodings, ALU op
// codes, opcode/funct values, ALUSrcB/PCSource selects and the DECODE dispatch table.
package mips_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEM_ADDR = 4'd2,
        MEM_RD   = 4'd3,
        MEM_WB   = 4'd4,
        MEM_WR   = 4'd5,
        EXEC_R   = 4'd6,
        EXEC_I   = 4'd7,
        ALU_WB   = 4'd8,
        BRANCH   = 4'd9,
        JUMP     = 4'd10,
        TRAP     = 4'd11
    } state_t;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_SLT = 4'd7;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    localparam logic [1:0] SRCB_REG    = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    // Unknown opcodes map to FETCH here; the top decides whether that means NOP or TRAP.
    function automatic state_t dispatch(input logic [5:0] op);
        case (op)
            OP_RTYPE:                          return EXEC_R;
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: return EXEC_I;
            OP_LW, OP_SW:                      return MEM_ADDR;
            OP_BEQ, OP_BNE:                    return BRANCH;
            OP_J:                              return JUMP;
            default:                           return FETCH;
        endcase
    endfunction

    function automatic logic op_known(input logic [5:0] op);
        return dispatch(op) != FETCH;
    endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational ALUOp selection from (state, opcode, funct); address and PC
// arithmetic states fall through to add, BRANCH compares with subtract.
module alu_decode
    import mips_pkg::*;
(
    input  logic [3:0] state,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [3:0] alu_op
);

    always_comb begin
        alu_op = ALU_ADD;
        case (state_t'(state))
            EXEC_R: begin
                case (funct)
                    F_SUB:   alu_op = ALU_SUB;
                    F_AND:   alu_op = ALU_AND;
                    F_OR:    alu_op = ALU_OR;
                    F_SLT:   alu_op = ALU_SLT;
                    default: alu_op = ALU_ADD;
                endcase
            end
            EXEC_I: begin
                case (opcode)
                    OP_ANDI: alu_op = ALU_AND;
                    OP_ORI:  alu_op = ALU_OR;
                    OP_SLTI: alu_op = ALU_SLT;
                    default: alu_op = ALU_ADD;
                endcase
            end
            BRANCH:  alu_op = ALU_SUB;
            default: alu_op = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM. Optional illegal-opcode trap enabled by
// defining MULTICYCLE_CONTROL_TRAP_EN; otherwise unknown opcodes act as NOPs.
module multicycle_control
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    output logic        PCWrite,
    output logic        PCWriteCond,
    output logic        BranchNe,
    output logic        IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        MemToReg,
    output logic        RegDst,
    output logic        RegWrite,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  PCSource,
    output logic [3:0]  ALUOp,
    output logic        illegal,
    output logic [3:0]  state
);

    state_t     state_reg;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       unused_bits;

    assign opcode      = instr[31:26];
    assign funct       = instr[5:0];
    assign unused_bits = ^instr[25:6];
    assign state       = state_reg;

`ifdef MULTICYCLE_CONTROL_TRAP_EN
    logic illegal_reg;
    assign illegal = illegal_reg;
`else
    assign illegal = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= FETCH;
`ifdef MULTICYCLE_CONTROL_TRAP_EN
            illegal_reg <= 1'b0;
`endif
        end else begin
            case (state_reg)
                FETCH:    if (mem_ready) state_reg <= DECODE;
                DECODE: begin
                    state_reg <= dispatch(opcode);
`ifdef MULTICYCLE_CONTROL_TRAP_EN
                    if (!op_known(opcode)) begin
                        state_reg   <= TRAP;
                        illegal_reg <= 1'b1;
                    end
`endif
                end
                MEM_ADDR: state_reg <= (opcode == OP_LW) ? MEM_RD : MEM_WR;
                MEM_RD:   if (mem_ready) state_reg <= MEM_WB;
                MEM_WR:   if (mem_ready) state_reg <= FETCH;
                EXEC_R:   state_reg <= ALU_WB;
                EXEC_I:   state_reg <= ALU_WB;
`ifdef MULTICYCLE_CONTROL_TRAP_EN
                TRAP:     state_reg <= TRAP;
`endif
                default:  state_reg <= FETCH;
            endcase
        end
    end

    alu_decode u_alu_decode (
        .state  (state_reg),
        .opcode (opcode),
        .funct  (funct),
        .alu_op (ALUOp)
    );

    // IRWrite/PCWrite in FETCH follow mem_ready so the PC advances only on a completed read.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        BranchNe    = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemToReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_REG;
        PCSource    = PCSRC_ALU;
        case (state_reg)
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            DECODE:   ALUSrcB = SRCB_IMM_SH;
            EXEC_R:   ALUSrcA = 1'b1;
            EXEC_I: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            ALU_WB: begin
                RegWrite = 1'b1;
                RegDst   = (opcode == OP_RTYPE);
            end
            MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            MEM_RD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            MEM_WB: begin
                RegWrite = 1'b1;
                MemToReg = 1'b1;
            end
            MEM_WR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            BRANCH: begin
                ALUSrcA     = 1'b1;
                PCWriteCond = 1'b1;
                PCSource    = PCSRC_ALUOUT;
                BranchNe    = (opcode == OP_BNE);
            end
            JUMP: begin
                PCWrite  = 1'b1;
                PCSource = PCSRC_JUMP;
            end
            default: ;
        endcase
    end

endmodule
